// File: rtl/image_scanout_pkg.sv
// image_scanout_pkg
// Shared constants and helpers for the image scanout path:
//   - default 240p raster timing (320x240 visible, 429x262 total)
//   - 11-entry brightness multiplier table (level 0..10, x/256)
//   - rgb332_expand: RGB332 byte -> three 8-bit components
package image_scanout_pkg;

  localparam int DEF_CE_DIV   = 4;
  localparam int DEF_H_ACTIVE = 320;
  localparam int DEF_H_FP     = 18;
  localparam int DEF_H_SYNC   = 32;
  localparam int DEF_H_BP     = 59;
  localparam int DEF_V_ACTIVE = 240;
  localparam int DEF_V_FP     = 4;
  localparam int DEF_V_SYNC   = 3;
  localparam int DEF_V_BP     = 15;
  localparam int DEF_H_TOTAL  = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int DEF_V_TOTAL  = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

  localparam int ADDR_W    = 17;
  localparam int LEVEL_MAX = 10;

  // Brightness multipliers in 1/256 steps; the top entry (256) is unity gain.
  localparam logic [8:0] MUL_TABLE [0:LEVEL_MAX] = '{
    9'd0, 9'd26, 9'd51, 9'd77, 9'd102, 9'd128,
    9'd154, 9'd179, 9'd205, 9'd230, 9'd256
  };

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb888_t;

  // Bit replication keeps full-scale input at full-scale output (7 -> 0xFF).
  function automatic rgb888_t rgb332_expand(input logic [7:0] d);
    rgb888_t c;
    c.r = {d[7:5], d[7:5], d[7:6]};
    c.g = {d[4:2], d[4:2], d[4:3]};
    c.b = {d[1:0], d[1:0], d[1:0], d[1:0]};
    return c;
  endfunction

  // Levels above the table clamp to unity gain.
  function automatic logic [8:0] level_mul(input logic [3:0] level);
    logic [3:0] idx;
    idx = (level > 4'(LEVEL_MAX)) ? 4'(LEVEL_MAX) : level;
    return MUL_TABLE[idx];
  endfunction

  // (c * m) >> 8, truncated to 8 bits; m = 256 returns c unchanged.
  function automatic logic [7:0] scale8(input logic [7:0] c, input logic [8:0] m);
    return 8'((17'(c) * 17'(m)) >> 8);
  endfunction

endpackage

// File: rtl/image_scanout_if.sv
// image_scanout_if
// Bundles the RAM read port and the emu video port of the scanout block.
//   master: the scanout (drives ram_addr and video), slave: RAM + video sink.
// Protocol: every signal is qualified by ce_pix. The master updates
// ram_addr/h_sync/v_sync/de/r/g/b only in the clk where ce_pix rises and
// holds them otherwise; the sink samples them while ce_pix is high. The RAM
// returns ram_data registered, one clk after ram_addr, with no back-pressure.
interface image_scanout_if;
  import image_scanout_pkg::*;

  logic [ADDR_W-1:0] ram_addr;
  logic [7:0]        ram_data;
  logic              ce_pix;
  logic              h_sync;
  logic              v_sync;
  logic              de;
  logic [7:0]        r;
  logic [7:0]        g;
  logic [7:0]        b;

  modport master (
    output ram_addr,
    input  ram_data,
    output ce_pix, h_sync, v_sync, de, r, g, b
  );

  modport slave (
    input  ram_addr,
    output ram_data,
    input  ce_pix, h_sync, v_sync, de, r, g, b
  );
endinterface

// File: rtl/image_scanout_timing.sv
// video_timing
// Pixel-enable divider plus horizontal/vertical raster counters.
// Ports:
//   clk, reset_n   clock and async active-low reset
//   tick           one-clk pulse every CE_DIV clks; counters advance on it
//   ce_pix         registered copy of tick (goes high with the new pixel)
//   active         current position is inside the visible window
//   hsync, vsync   current position is inside the sync pulse region
//   frame_wrap     current position is the last one of the frame
module video_timing
  import image_scanout_pkg::*;
#(
  parameter int CE_DIV   = DEF_CE_DIV,
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP
) (
  input  logic clk,
  input  logic reset_n,
  output logic tick,
  output logic ce_pix,
  output logic active,
  output logic hsync,
  output logic vsync,
  output logic frame_wrap
);

  localparam int HT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int VT = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW = $clog2(HT);
  localparam int VW = $clog2(VT);
  localparam int CW = $clog2(CE_DIV);

  logic [CW-1:0] ce_cnt;
  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic          h_last;
  logic          v_last;

  assign tick   = (ce_cnt == CW'(CE_DIV - 1));
  assign h_last = (h_cnt == HW'(HT - 1));
  assign v_last = (v_cnt == VW'(VT - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ce_cnt <= '0;
      ce_pix <= 1'b0;
      h_cnt  <= '0;
      v_cnt  <= '0;
    end else begin
      ce_pix <= tick;
      ce_cnt <= tick ? '0 : ce_cnt + 1'b1;
      if (tick) begin
        h_cnt <= h_last ? '0 : h_cnt + 1'b1;
        if (h_last) begin
          v_cnt <= v_last ? '0 : v_cnt + 1'b1;
        end
      end
    end
  end

  assign active     = (h_cnt < HW'(H_ACTIVE)) && (v_cnt < VW'(V_ACTIVE));
  assign hsync      = (h_cnt >= HW'(H_ACTIVE + H_FP)) &&
                      (h_cnt <  HW'(H_ACTIVE + H_FP + H_SYNC));
  // vsync depends on v only, so it covers whole lines.
  assign vsync      = (v_cnt >= VW'(V_ACTIVE + V_FP)) &&
                      (v_cnt <  VW'(V_ACTIVE + V_FP + V_SYNC));
  assign frame_wrap = h_last && v_last;

endmodule

// File: rtl/image_scanout.sv
// image_scanout
// Reads an RGB332 image back from the loader's dual-port RAM and drives it
// as a raster on the emu video port, with 11-step brightness scaling.
// Ports:
//   clk, reset_n   system clock, async active-low reset
//   layer_level    brightness 0..10 (11..15 behave as 10)
//   blank_image    forces black pixels; timing keeps running
//   vid            image_scanout_if.master: ram_addr/ram_data, ce_pix,
//                  h_sync, v_sync, de, r, g, b
// Pipeline, in pixel ticks from the raster position at tick k:
//   k   : ram_addr registered, sync/de captured (stage 1)
//   k+1 : ram_data expanded, blank/de gating, level sampled (stage 2)
//   k+2 : scaled colour and delayed sync/de drive the outputs
module image_scanout
  import image_scanout_pkg::*;
#(
  parameter int CE_DIV   = DEF_CE_DIV,
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [3:0]            layer_level,
  input  logic                  blank_image,
  image_scanout_if.master       vid
);

  logic tick;
  logic active;
  logic hsync;
  logic vsync;
  logic frame_wrap;

  video_timing #(
    .CE_DIV   (CE_DIV),
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP)
  ) u_timing (
    .clk        (clk),
    .reset_n    (reset_n),
    .tick       (tick),
    .ce_pix     (vid.ce_pix),
    .active     (active),
    .hsync      (hsync),
    .vsync      (vsync),
    .frame_wrap (frame_wrap)
  );

  logic [ADDR_W-1:0] addr_cnt;
  logic              de1, hs1, vs1;
  logic              de2, hs2, vs2;
  rgb888_t           pix2;
  logic [8:0]        mul2;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_cnt     <= '0;
      vid.ram_addr <= '0;
      de1          <= 1'b0;
      hs1          <= 1'b0;
      vs1          <= 1'b0;
      de2          <= 1'b0;
      hs2          <= 1'b0;
      vs2          <= 1'b0;
      pix2         <= '0;
      mul2         <= '0;
      vid.de       <= 1'b0;
      vid.h_sync   <= 1'b0;
      vid.v_sync   <= 1'b0;
      vid.r        <= '0;
      vid.g        <= '0;
      vid.b        <= '0;
    end else if (tick) begin
      // Stage 1: the image is stored row-major with no gaps, so a counter
      // that steps only on visible pixels yields line n at n*H_ACTIVE.
      vid.ram_addr <= addr_cnt;
      if (frame_wrap) begin
        addr_cnt <= '0;
      end else if (active) begin
        addr_cnt <= addr_cnt + 1'b1;
      end
      de1 <= active;
      hs1 <= hsync;
      vs1 <= vsync;

      // Stage 2: gating to black here keeps porch/sync periods at zero.
      de2  <= de1;
      hs2  <= hs1;
      vs2  <= vs1;
      mul2 <= level_mul(layer_level);
      pix2 <= (de1 && !blank_image) ? rgb332_expand(vid.ram_data) : '0;

      // Stage 3: outputs.
      vid.de     <= de2;
      vid.h_sync <= hs2;
      vid.v_sync <= vs2;
      vid.r      <= scale8(pix2.r, mul2);
      vid.g      <= scale8(pix2.g, mul2);
      vid.b      <= scale8(pix2.b, mul2);
    end
  end

endmodule

// File: tb/tb_image_scanout.sv
// tb_image_scanout
// Bench for image_scanout on a reduced raster (32x24 visible, 50x32 total)
// so several frames fit in a short run. A raster model predicts every output
// pixel; a constant table checks colour expansion and brightness.
module tb_image_scanout;

  localparam int CE  = 4;
  localparam int HA  = 32;
  localparam int HFP = 4;
  localparam int HSW = 6;
  localparam int HBP = 8;
  localparam int VA  = 24;
  localparam int VFP = 2;
  localparam int VSW = 3;
  localparam int VBP = 3;
  localparam int HT  = HA + HFP + HSW + HBP;
  localparam int VT  = VA + VFP + VSW + VBP;

  // ---------------- clock / reset ----------------
  logic       clk;
  logic       reset_n;
  logic [3:0] level;
  logic       blank;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  image_scanout_if vif();

  image_scanout #(
    .CE_DIV (CE), .H_ACTIVE (HA), .H_FP (HFP), .H_SYNC (HSW), .H_BP (HBP),
    .V_ACTIVE (VA), .V_FP (VFP), .V_SYNC (VSW), .V_BP (VBP)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .layer_level (level),
    .blank_image (blank),
    .vid         (vif)
  );

  // RAM model: registered read, either addr[7:0] or a constant byte.
  logic       ram_mode;
  logic [7:0] ram_const;
  always @(posedge clk) vif.ram_data <= ram_mode ? ram_const : vif.ram_addr[7:0];

  // ---------------- scoreboard ----------------
  int cmp_cnt;
  int err_cnt;
  int t;          // pixel ticks since reset release
  int last_wait;  // clks waited by the last tick_step
  logic [26:0] exp_q[$];
  int mul_tab[11] = '{0, 26, 51, 77, 102, 128, 154, 179, 205, 230, 256};

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    cmp_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s t=%0d got=%h exp=%h", name, t, got, exp);
    end
  endtask

  function automatic int pos_h(input int tt);
    return tt % HT;
  endfunction

  function automatic int pos_v(input int tt);
    return (tt / HT) % VT;
  endfunction

  // Expected {hsync, vsync, de, r, g, b} for the raster position of tick tt.
  function automatic logic [26:0] model_pix(input int tt, input logic [3:0] lvl,
                                            input logic blk, input logic mode,
                                            input logic [7:0] cdata);
    int h, v, addr, m;
    logic [7:0] d, cr, cg, cb, orr, og, ob;
    logic hs, vs, de;
    h    = pos_h(tt);
    v    = pos_v(tt);
    de   = (h < HA) && (v < VA);
    hs   = (h >= HA + HFP) && (h < HA + HFP + HSW);
    vs   = (v >= VA + VFP) && (v < VA + VFP + VSW);
    addr = v * HA + h;
    d    = mode ? cdata : addr[7:0];
    cr   = {d[7:5], d[7:5], d[7:6]};
    cg   = {d[4:2], d[4:2], d[4:3]};
    cb   = {d[1:0], d[1:0], d[1:0], d[1:0]};
    m    = mul_tab[(lvl > 4'd10) ? 10 : int'(lvl)];
    if (!de || blk) begin
      orr = 8'h00; og = 8'h00; ob = 8'h00;
    end else begin
      orr = 8'((int'(cr) * m) >> 8);
      og  = 8'((int'(cg) * m) >> 8);
      ob  = 8'((int'(cb) * m) >> 8);
    end
    return {hs, vs, de, orr, og, ob};
  endfunction

  // ---------------- driver tasks ----------------
  // Waits for the next pixel tick and samples 1 ns after it. Stimulus
  // present now was seen by the DUT at this tick, i.e. by stage 2 of the
  // previous tick's pixel, so that pixel's expectation is pushed now.
  task automatic tick_step();
    logic found;
    logic [26:0] exp_v;
    found = 1'b0;
    last_wait = 0;
    for (int i = 0; i < CE + 1 && !found; i++) begin
      @(posedge clk);
      #1;
      last_wait++;
      if (vif.ce_pix) found = 1'b1;
    end
    if (!found) begin
      check("ce_timeout", 64'd0, 64'd1);
      return;
    end
    if (t >= 1) exp_q.push_back(model_pix(t - 1, level, blank, ram_mode, ram_const));
    if (t >= 2 && exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      check("pix", {37'd0, vif.h_sync, vif.v_sync, vif.de, vif.r, vif.g, vif.b}, {37'd0, exp_v});
    end
    if (pos_h(t) < HA && pos_v(t) < VA)
      check("ram_addr", 64'(vif.ram_addr), 64'(pos_v(t) * HA + pos_h(t)));
    t++;
  endtask

  // Steps until the most recent tick was at raster position (h, v).
  task automatic wait_pos(input int h, input int v);
    logic found;
    found = 1'b0;
    for (int i = 0; i < HT * VT + 1 && !found; i++) begin
      tick_step();
      if (pos_h(t - 1) == h && pos_v(t - 1) == v) found = 1'b1;
    end
    if (!found) check("wait_pos_timeout", 64'd0, 64'd1);
  endtask

  function automatic logic [63:0] all_outs();
    return {19'd0, vif.ce_pix, vif.h_sync, vif.v_sync, vif.de,
            vif.r, vif.g, vif.b, vif.ram_addr};
  endfunction

  task automatic do_reset();
    reset_n = 1'b0;
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1;
    check("reset_outs", all_outs(), 64'd0);
    t = 0;
    reset_n = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      @(posedge clk);
      #1;
      check("ce_early", 64'(vif.ce_pix), 64'd0);
    end
    tick_step();
    check("ce_first_clk4", 64'(last_wait), 64'd1);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [7:0] d;
    logic [3:0] l;
    logic       bl;
    logic [7:0] er;
    logic [7:0] eg;
    logic [7:0] eb;
  } vec_t;
  vec_t vecs[10];

  int de_n, vs_rise, vs_hi, nz, pos, first_de, vs_tick;
  logic prev_vs, seen_de;

  initial begin
    vecs[0] = '{8'hE0, 4'd10, 1'b0, 8'hFF, 8'h00, 8'h00};
    vecs[1] = '{8'hE0, 4'd5,  1'b0, 8'h7F, 8'h00, 8'h00};
    vecs[2] = '{8'hE0, 4'd0,  1'b0, 8'h00, 8'h00, 8'h00};
    vecs[3] = '{8'hE0, 4'd15, 1'b0, 8'hFF, 8'h00, 8'h00};
    vecs[4] = '{8'h1F, 4'd10, 1'b0, 8'h00, 8'hFF, 8'hFF};
    vecs[5] = '{8'h49, 4'd10, 1'b0, 8'h49, 8'h49, 8'h55};
    vecs[6] = '{8'h49, 4'd3,  1'b0, 8'h15, 8'h15, 8'h19};
    vecs[7] = '{8'hFF, 4'd1,  1'b0, 8'h19, 8'h19, 8'h19};
    vecs[8] = '{8'h92, 4'd7,  1'b0, 8'h66, 8'h66, 8'h76};
    vecs[9] = '{8'hFF, 4'd10, 1'b1, 8'h00, 8'h00, 8'h00};

    cmp_cnt = 0; err_cnt = 0; t = 0;
    level = 4'd10; blank = 1'b0; ram_mode = 1'b0; ram_const = 8'h00;
    reset_n = 1'b0;

    // Full frame with addr[7:0] data: timing counts and address landmarks.
    do_reset();
    de_n = 0; vs_rise = 0; vs_hi = 0; prev_vs = 1'b0; seen_de = 1'b0;
    for (int i = 0; i < HT * VT; i++) begin
      tick_step();
      pos = (t - 1) % (HT * VT);
      if (pos == HT) check("addr_line1", 64'(vif.ram_addr), 64'(HA));
      if (pos == (VA - 1) * HT + HA - 1) check("addr_last", 64'(vif.ram_addr), 64'(HA * VA - 1));
      if (vif.de && !seen_de) begin
        seen_de = 1'b1;
        check("first_de_rgb", 64'({vif.r, vif.g, vif.b}), 64'd0);
      end
      if (vif.de) de_n++;
      if (vif.v_sync && !prev_vs) vs_rise++;
      if (vif.v_sync) vs_hi++;
      prev_vs = vif.v_sync;
    end
    check("frame_de_count", 64'(de_n), 64'(HA * VA));
    check("frame_vs_rises", 64'(vs_rise), 64'd1);
    check("frame_vs_ticks", 64'(vs_hi), 64'(VSW * HT));

    // Colour/brightness table, one vector per line.
    ram_mode = 1'b1;
    for (int i = 0; i < 10; i++) begin
      wait_pos(4, i + 1);
      ram_const = vecs[i].d;
      level     = vecs[i].l;
      blank     = vecs[i].bl;
      tick_step();
      tick_step();
      check($sformatf("vec%0d_rgb", i), 64'({vif.r, vif.g, vif.b}),
            64'({vecs[i].er, vecs[i].eg, vecs[i].eb}));
    end

    // blank_image held for a whole frame.
    ram_const = 8'hFF; level = 4'd10; blank = 1'b0;
    wait_pos(0, VA);
    blank = 1'b1;
    de_n = 0; nz = 0; vs_hi = 0;
    for (int i = 0; i < HT * VT; i++) begin
      tick_step();
      if (vif.de) de_n++;
      if ({vif.r, vif.g, vif.b} != 24'h0) nz++;
      if (vif.v_sync) vs_hi++;
    end
    check("blank_de_count", 64'(de_n), 64'(HA * VA));
    check("blank_nonzero", 64'(nz), 64'd0);
    check("blank_vs_ticks", 64'(vs_hi), 64'(VSW * HT));
    wait_pos(4, 0);
    blank = 1'b0;
    tick_step();
    check("blank_hold_1tick", 64'({vif.r, vif.g, vif.b}), 64'd0);
    tick_step();
    check("blank_release", 64'({vif.r, vif.g, vif.b}), 64'hFFFFFF);

    // Mid-frame reset: immediate clear, then restart from the origin.
    ram_mode = 1'b0; level = 4'd10;
    wait_pos(20, 10);
    check("pre_reset_de", 64'(vif.de), 64'd1);
    reset_n = 1'b0;
    #1;
    check("reset_async", all_outs(), 64'd0);
    do_reset();
    first_de = -1; vs_tick = -1;
    for (int i = 0; i < (VA + VFP + 1) * HT && vs_tick < 0; i++) begin
      tick_step();
      if (vif.de && first_de < 0) begin
        first_de = t;
        check("restart_first_rgb", 64'({vif.r, vif.g, vif.b}), 64'd0);
      end
      if (vif.v_sync && first_de >= 0) vs_tick = t;
    end
    check("restart_vsync_delay", 64'(vs_tick - first_de), 64'((VA + VFP) * HT));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
